he_pixel_streamer: RTL and testbench
====================================

Name: he_pixel_streamer

Overview:
- Frame source on the transmit side of the pixel stream consumed by the histogram-equalization block.
- Reads an 8-bit grayscale frame from an external synchronous image memory and sends it as a valid/ready pixel stream.
- Sends the whole frame NUM_PASSES times: pass 0 feeds histogram accumulation, pass 1 feeds the equalized output.
- Inserts a programmable idle gap between passes so the downstream block can finish its CDF and LUT computation.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame.
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- NUM_PASSES, 2, frame repetitions per start; range 1..4.
- GAP_CYCLES, 300, idle cycles between passes; 0 means the next pass starts immediately.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin streaming; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final pixel handshake of the last pass
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address, row-major (y*IMG_WIDTH + x)
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd
- pix_data  out  8  pixel value
- pix_valid  out  1  pixel present
- pix_ready  in  1  sink accepts; a transfer occurs when pix_valid && pix_ready
- pix_sof  out  1  qualifies the first pixel of a pass
- pix_eof  out  1  qualifies the last pixel of a pass
- pix_pass  out  2  current pass index, 0-based

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, address counter 0, pass counter 0, buffer empty.
- FSM states and transitions:
  - IDLE -> STREAM on start.
  - STREAM -> GAP when the last pixel of a pass is transferred and it is not the last pass.
  - GAP -> STREAM after GAP_CYCLES cycles; pass index increments, address restarts at 0.
  - STREAM -> DONE after the last pixel of the last pass is transferred.
  - DONE -> IDLE after 1 cycle; done=1 during DONE.
  - When GAP_CYCLES=0, STREAM goes directly to the next pass with no bubble required.
- Read pipeline:
  - 2-entry output FIFO/skid buffer.
  - mem_rd is issued only when (buffer occupancy + reads in flight) < 2 and pixels remain in the current pass.
  - mem_addr increments once per issued read.
  - Throughput is 1 pixel/clk with pix_ready held high.
  - First pix_valid is 2 cycles after start is sampled: mem_rd in cycle 1, data in cycle 2.
- Handshake rules:
  - While pix_valid && !pix_ready, pix_data, pix_sof, pix_eof and pix_pass hold stable.
  - pix_valid never drops without a transfer.
- Reads never cross a pass boundary. The address wraps to 0 only on entering the next pass.
- pix_sof and pix_eof are both 1 on the same pixel when IMG_WIDTH*IMG_HEIGHT = 1.
- pix_pass is registered with each buffered pixel, so it is correct even when the buffer still drains the previous pass.
- start in the same cycle as done is ignored; it is accepted only in IDLE.
- Reset mid-operation: immediate abort and return to reset values; an in-flight read result is discarded. No done pulse.
- Counters: pixel counter width ADDR_W+1; the pass counter compares against NUM_PASSES-1.

Optional Feature:
- Macro: HE_STREAM_PATTERN_EN.
- When defined:
  - Extra input port pattern_en (1 bit), sampled at start.
  - If it was 1, pixels are generated internally as (x + y) & 8'hFF.
  - mem_rd stays 0 for the whole run.
  - Timing, sof/eof, gap and done are identical to memory mode.
- When undefined: the port is absent and pixels always come from memory.

Test Plan:
- Frame of 4x2 pixels (memory 10,20..80), NUM_PASSES=2, GAP_CYCLES=3, pix_ready=1 -> 16 transfers, values 10..80 twice; sof on the 1st and 9th transfer, eof on the 8th and 16th; pix_pass 0 then 1; exactly 3 idle cycles between passes; done pulses once.
- Same frame, pix_ready toggling 1,0,0,1 repeatedly -> no lost or duplicated pixel; data stable while stalled; mem_rd never issued with 2 pixels already buffered or in flight.
- start pulsed while busy -> no effect; pixel count stays 16; busy drops in the cycle after done.
- reset asserted after the 5th transfer of pass 0 -> all outputs 0 immediately; a new start restarts at address 0 with sof and pix_pass=0.
- GAP_CYCLES=0, NUM_PASSES=1, 1x1 frame with value 0xAB -> single transfer with sof=eof=1 and data 0xAB; done on the following cycle.
- HE_STREAM_PATTERN_EN defined, pattern_en=1, 4x2 frame -> data 0,1,2,3,1,2,3,4 per pass; mem_rd never 1.

Source files
------------

// File: rtl/he_pixel_streamer.sv
// he_pixel_streamer: replays a frame from synchronous image memory NUM_PASSES times as a valid/ready pixel stream.
// Define HE_STREAM_PATTERN_EN to add pattern_en, which swaps memory reads for an internal (x+y) test pattern.
module he_pixel_streamer #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int ADDR_W     = 18,
   parameter int NUM_PASSES = 2,
   parameter int GAP_CYCLES = 300
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef HE_STREAM_PATTERN_EN
   input  logic              pattern_en,
`endif
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_sof,
   output logic              pix_eof,
   output logic [1:0]        pix_pass
);
   localparam logic [ADDR_W:0] NPIX    = (ADDR_W+1)'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [ADDR_W:0] NPIX_M1 = (ADDR_W+1)'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [1:0]      LAST    = 2'(NUM_PASSES - 1);
   localparam int              GW      = $clog2(GAP_CYCLES + 2);
   localparam logic [GW-1:0]   GAP_END = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;
   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       eof;
      logic [1:0] pass;
   } pix_t;

   state_t          state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic [1:0]      pass_q, pass_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [1:0]      occ_q, occ_d;
   logic            inf_q, inf_d;
   logic            pat_q, pat_d;
   pix_t            tag_q, tag_d, b0_q, b0_d, b1_q, b1_d;
   pix_t            resp, head, s0, s1;
   logic            rd, fire, valid, pat_in;
   logic [7:0]      pat_val;

`ifdef HE_STREAM_PATTERN_EN
   logic [ADDR_W-1:0] x_q, y_q;
   // x/y always describe pixel index cnt_d, so they zero whenever the read counter does
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else if (cnt_d == '0) begin
         x_q <= '0;
         y_q <= '0;
      end else if (rd) begin
         x_q <= (x_q == ADDR_W'(IMG_WIDTH - 1)) ? '0 : x_q + 1'b1;
         y_q <= (x_q == ADDR_W'(IMG_WIDTH - 1)) ? y_q + 1'b1 : y_q;
      end
   assign pat_in  = pattern_en;
   assign pat_val = 8'(x_q + y_q);
`else
   assign pat_in  = 1'b0;
   assign pat_val = 8'h00;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pass_q  <= '0;
         gap_q   <= '0;
         occ_q   <= '0;
         inf_q   <= 1'b0;
         pat_q   <= 1'b0;
         tag_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         gap_q   <= gap_d;
         occ_q   <= occ_d;
         inf_q   <= inf_d;
         pat_q   <= pat_d;
         tag_q   <= tag_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
      end

   // A returning read is presented straight from mem_rdata when the buffer is empty,
   // which gives 1 pixel/clk with the strict occupancy+in-flight < 2 issue rule.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      gap_d     = gap_q;
      pat_d     = pat_q;
      resp      = tag_q;
      resp.data = pat_q ? tag_q.data : mem_rdata;
      valid     = (occ_q != 2'd0) || inf_q;
      head      = (occ_q != 2'd0) ? b0_q : resp;
      fire      = valid && pix_ready;
      rd        = (state_q == STREAM || (state_q == GAP && gap_q == GAP_END)) && cnt_q != NPIX
                  && (occ_q + {1'b0, inf_q}) < 2'd2;
      inf_d     = rd;
      tag_d     = rd ? {pat_val, cnt_q == '0, cnt_q == NPIX_M1, pass_q} : tag_q;
      s0        = (occ_q != 2'd0) ? b0_q : resp;
      s1        = (occ_q == 2'd2) ? b1_q : resp;
      b0_d      = fire ? s1 : s0;
      b1_d      = fire ? resp : s1;
      occ_d     = occ_q + {1'b0, inf_q} - {1'b0, fire};
      if (rd)
         cnt_d = cnt_q + 1'b1;
      // Without a gap the next pass is fetched right behind the last read of this one
      if (GAP_CYCLES == 0 && rd && cnt_q == NPIX_M1 && pass_q != LAST) begin
         cnt_d  = '0;
         pass_d = pass_q + 2'd1;
      end
      case (state_q)
         IDLE:
            if (start) begin
               state_d = STREAM;
               cnt_d   = '0;
               pass_d  = '0;
               pat_d   = pat_in;
            end
         STREAM:
            if (fire && head.eof && head.pass == LAST)
               state_d = DONE;
            else if (fire && head.eof && GAP_CYCLES != 0) begin
               state_d = GAP;
               gap_d   = '0;
               cnt_d   = '0;
               pass_d  = pass_q + 2'd1;
            end
         GAP:
            if (gap_q == GAP_END)
               state_d = STREAM;
            else
               gap_d = gap_q + 1'b1;
         default:
            state_d = IDLE;
      endcase
   end

   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign mem_rd    = rd && !pat_q;
   assign mem_addr  = cnt_q[ADDR_W-1:0];
   assign pix_valid = valid;
   assign pix_data  = valid ? head.data : 8'h00;
   assign pix_sof   = valid && head.sof;
   assign pix_eof   = valid && head.eof;
   assign pix_pass  = valid ? head.pass : 2'd0;
endmodule

// File: tb/tb_he_pixel_streamer.sv
// tb_he_pixel_streamer: scoreboard bench for he_pixel_streamer on a 4x2 two-pass frame plus a 1x1 single-pass instance.
module tb_he_pixel_streamer;
   localparam int W = 4, H = 2, N = W * H, NP = 2, GAP = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, busy, done, mem_rd, pix_valid, pix_sof, pix_eof;
   logic       pix_ready = 1'b1;
   logic [2:0] mem_addr;
   logic [7:0] mem_rdata, pix_data;
   logic [1:0] pix_pass;
   logic       s_start, s_busy, s_done, s_mem_rd, s_ready, s_valid, s_sof, s_eof;
   logic [0:0] s_addr;
   logic [7:0] s_rdata, s_data;
   logic [1:0] s_pass;
`ifdef HE_STREAM_PATTERN_EN
   logic       pat_en;
`endif

   logic [7:0]  mem [N];
   logic [11:0] exp_q [$];
   logic [11:0] prev, e;
   int checks = 0, failures = 0;
   int rmode = 0, ph = 0, run_x = 0, done_cnt = 0, issued = 0, xfers = 0, gap_cnt = -1;
   bit cur_pat = 1'b0, stall_v = 1'b0, last_final = 1'b0;

   he_pixel_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(3), .NUM_PASSES(NP), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef HE_STREAM_PATTERN_EN
      .pattern_en(pat_en),
`endif
      .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_sof(pix_sof), .pix_eof(pix_eof), .pix_pass(pix_pass)
   );

   he_pixel_streamer #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .ADDR_W(1), .NUM_PASSES(1), .GAP_CYCLES(0)) dut_s (
      .clk(clk), .reset(reset), .start(s_start),
`ifdef HE_STREAM_PATTERN_EN
      .pattern_en(1'b0),
`endif
      .busy(s_busy), .done(s_done), .mem_rd(s_mem_rd), .mem_addr(s_addr), .mem_rdata(s_rdata),
      .pix_data(s_data), .pix_valid(s_valid), .pix_ready(s_ready),
      .pix_sof(s_sof), .pix_eof(s_eof), .pix_pass(s_pass)
   );

   // Read data is only meaningful the cycle after a strobe; junk otherwise
   always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);
   always @(posedge clk) s_rdata <= s_mem_rd ? 8'hAB : 8'($urandom);

   always @(posedge clk) begin
      #1;
      ph++;
      pix_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         issued = 0; xfers = 0; gap_cnt = -1; stall_v = 1'b0; last_final = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            chk("done_after_last", 32'(last_final), 1);
         end
         last_final = 1'b0;
         if (cur_pat) chk("no_mem_rd_pattern", 32'(mem_rd), 0);
         if (mem_rd) chk("rd_budget", 32'((issued - xfers) < 2), 1);
         if (stall_v) chk("stall_hold", {pix_valid, pix_data, pix_sof, pix_eof, pix_pass}, {1'b1, prev});
         if (gap_cnt >= 0) begin
            if (pix_valid) begin
               chk("gap_len", gap_cnt, GAP);
               gap_cnt = -1;
            end else gap_cnt++;
         end
         if (pix_valid && pix_ready) begin
            chk("xfer_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("xfer", {pix_data, pix_sof, pix_eof, pix_pass}, e);
            end
            run_x++; xfers++;
            last_final = pix_eof && pix_pass == 2'(NP - 1);
            if (pix_eof && pix_pass != 2'(NP - 1)) gap_cnt = 0;
         end
         if (mem_rd) issued++;
         stall_v = pix_valid && !pix_ready;
         prev = {pix_data, pix_sof, pix_eof, pix_pass};
      end
   end

   task automatic run(input bit pat, input int mode, input bit poke, input int abort_at);
      int k;
      rmode = mode;
      cur_pat = pat;
`ifdef HE_STREAM_PATTERN_EN
      pat_en = pat;
`endif
      for (int p = 0; p < NP; p++)
         for (int i = 0; i < N; i++)
            exp_q.push_back({pat ? 8'((i % W) + (i / W)) : mem[i], i == 0, i == N - 1, 2'(p)});
      run_x = 0;
      done_cnt = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("busy_after_start", 32'(busy), 1);
      chk("first_rd", {mem_rd, mem_addr}, {!pat, 3'd0});
      @(negedge clk) chk("first_valid", 32'(pix_valid), 1);
      k = 0;
      while (!done && k < 300 && !(abort_at > 0 && run_x >= abort_at)) begin
         @(negedge clk);
         k++;
         start = poke && (k % 5 == 2);
      end
      if (abort_at > 0) begin
         chk("abort_reached", 32'(run_x >= abort_at), 1);
         reset = 1'b1;
         start = 1'b0;
         #1;
         chk("abort_outputs", {busy, done, mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eof, pix_pass}, 0);
         exp_q.delete();
         @(negedge clk);
         @(negedge clk) reset = 1'b0;
      end else begin
         chk("done_seen", 32'(done), 1);
         start = poke;
         @(negedge clk) start = 1'b0;
         chk("busy_drop", 32'(busy), 0);
         chk("done_once", done_cnt, 1);
         chk("xfer_count", run_x, NP * N);
         @(negedge clk) chk("still_idle", {busy, pix_valid, done}, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      s_start = 1'b0;
      s_ready = 1'b1;
`ifdef HE_STREAM_PATTERN_EN
      pat_en = 1'b0;
`endif
      for (int i = 0; i < N; i++) mem[i] = 8'(10 * (i + 1));
      repeat (3) @(negedge clk);
      chk("reset_outputs", {busy, done, mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eof, pix_pass}, 0);
      chk("s_reset_outputs", {s_busy, s_done, s_mem_rd, s_addr, s_valid, s_data, s_sof, s_eof, s_pass}, 0);
      reset = 1'b0;
      run(1'b0, 0, 1'b0, 0);
      run(1'b0, 1, 1'b0, 0);
      run(1'b0, 1, 1'b1, 0);
      run(1'b0, 0, 1'b0, 5);
      run(1'b0, 0, 1'b0, 0);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
         run(1'b0, 2, r[0], 0);
      end
`ifdef HE_STREAM_PATTERN_EN
      run(1'b1, 1, 1'b0, 0);
      run(1'b1, 2, 1'b1, 0);
      run(1'b0, 2, 1'b0, 0);
`endif
      s_ready = 1'b0;
      @(negedge clk) s_start = 1'b1;
      @(negedge clk) s_start = 1'b0;
      chk("s_rd", {s_mem_rd, s_addr}, 2'b10);
      for (int i = 0; i < 3; i++)
         @(negedge clk) chk("s_pixel_held", {s_valid, s_data, s_sof, s_eof, s_pass, s_done},
                            {1'b1, 8'hAB, 1'b1, 1'b1, 2'd0, 1'b0});
      s_ready = 1'b1;
      @(negedge clk) chk("s_done", {s_done, s_busy, s_valid}, 3'b110);
      @(negedge clk) chk("s_idle", {s_done, s_busy}, 2'b00);
      @(negedge clk) s_start = 1'b1;
      @(negedge clk) s_start = 1'b0;
      @(negedge clk) chk("s_fast_pixel", {s_valid, s_data, s_sof, s_eof}, {1'b1, 8'hAB, 2'b11});
      @(negedge clk) chk("s_fast_done", 32'(s_done), 1);
      @(negedge clk) chk("s_fast_idle", {s_done, s_busy}, 2'b00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
